// File: rtl/branch_pred_pkg.sv
// Shared types for the branch predictor: opcodes, 2-bit counter encodings,
// the redirect FSM states and the saturating counter update.
package branch_pred_pkg;

   localparam logic [6:0] BRANCH_EQ = 7'b1100011;
   localparam logic [6:0] JUMP      = 7'b1101111;

   typedef logic [1:0] ctr_t;

   localparam ctr_t STRONG_NT = 2'b00;
   localparam ctr_t WEAK_NT   = 2'b01;
   localparam ctr_t WEAK_T    = 2'b10;
   localparam ctr_t STRONG_T  = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } redir_state_t;

   // Saturating step toward the observed outcome.
   function automatic ctr_t ctr_next(input ctr_t cnt, input logic taken);
      ctr_t result;
      result = cnt;
      if (taken) begin
         if (cnt != STRONG_T) result = cnt + 2'd1;
      end else begin
         if (cnt != STRONG_NT) result = cnt - 2'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Branch history table: 2^IDX_W saturating counters with one combinational
// read port and one saturating-update write port; resets to WEAK_NT.
module bht_table
   import branch_pred_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [IDX_W-1:0] rd_idx,
   output ctr_t             rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam int DEPTH = 1 << IDX_W;

   ctr_t cnt_reg [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               cnt_reg[gi] <= WEAK_NT;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               cnt_reg[gi] <= ctr_next(cnt_reg[gi], wr_taken);
            end
         end
      end
   endgenerate

   // No bypass: a same-cycle write is seen by the reader one cycle later.
   assign rd_cnt = cnt_reg[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with mispredict redirect sequencer.
// Optional perf counters are built when BRANCH_PRED_PERF_EN is defined.
module branch_predictor
   import branch_pred_pkg::*;
#(
   parameter int PC_W  = 64,
   parameter int IDX_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic [PC_W-1:0]  if_pc,
   input  logic [6:0]       if_opcode,
   output logic             prediction,
   input  logic             ex_branch_valid,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic             ex_taken,
   input  logic             ex_pred,
   input  logic             stall,
   output logic             branchtaken,
   output logic             redirect_taken
`ifdef BRANCH_PRED_PERF_EN
   ,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
`endif
);

   redir_state_t state_reg;
   logic         held_taken_reg;
   ctr_t         rd_cnt;
   logic         accept;
   logic         mis;

   // EX is frozen while a held redirect is pending, so its inputs are ignored.
   assign accept = ex_branch_valid && (state_reg == IDLE);
   assign mis    = accept && (ex_taken != ex_pred);

   bht_table #(
      .IDX_W (IDX_W)
   ) u_bht (
      .clk      (clk),
      .arst     (arst),
      .rd_idx   (if_pc[IDX_W+1:2]),
      .rd_cnt   (rd_cnt),
      .wr_en    (accept),
      .wr_idx   (ex_pc[IDX_W+1:2]),
      .wr_taken (ex_taken)
   );

   always_comb begin
      prediction = 1'b0;
      case (if_opcode)
         BRANCH_EQ: prediction = rd_cnt[1];
         JUMP:      prediction = 1'b1;
         default:   prediction = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg      <= IDLE;
         held_taken_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mis && stall) begin
                  state_reg      <= HOLD;
                  held_taken_reg <= ex_taken;
               end
            end
            HOLD: begin
               if (!stall) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // IDLE presents the request the same cycle; HOLD replays the latched one.
   assign branchtaken    = (state_reg == HOLD) || mis;
   assign redirect_taken = (state_reg == HOLD) ? held_taken_reg : (mis && ex_taken);

`ifdef BRANCH_PRED_PERF_EN
   logic [CNT_W-1:0] branch_cnt_reg;
   logic [CNT_W-1:0] mispred_cnt_reg;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         branch_cnt_reg  <= '0;
         mispred_cnt_reg <= '0;
      end else begin
         if (accept) branch_cnt_reg  <= branch_cnt_reg + 1'b1;
         if (mis)    mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
      end
   end

   assign branch_cnt  = branch_cnt_reg;
   assign mispred_cnt = mispred_cnt_reg;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                             ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0], rd_cnt[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table-driven prediction/training
// checks plus hand-written stall-hold, reset-in-hold and perf-counter sequences.
module tb_branch_predictor;

   localparam int PC_W  = 64;
   localparam int IDX_W = 4;
   localparam int CNT_W = 4;

   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JMP = 7'b1101111;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic             clk;
   logic             arst;
   logic [PC_W-1:0]  if_pc;
   logic [6:0]       if_opcode;
   logic             prediction;
   logic             ex_branch_valid;
   logic [PC_W-1:0]  ex_pc;
   logic             ex_taken;
   logic             ex_pred;
   logic             stall;
   logic             branchtaken;
   logic             redirect_taken;
`ifdef BRANCH_PRED_PERF_EN
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   branch_predictor #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk             (clk),
      .arst            (arst),
      .if_pc           (if_pc),
      .if_opcode       (if_opcode),
      .prediction      (prediction),
      .ex_branch_valid (ex_branch_valid),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_pred         (ex_pred),
      .stall           (stall),
      .branchtaken     (branchtaken),
      .redirect_taken  (redirect_taken)
`ifdef BRANCH_PRED_PERF_EN
      ,
      .branch_cnt      (branch_cnt),
      .mispred_cnt     (mispred_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [15:0] pc;
      logic        ev;
      logic [15:0] epc;
      logic        et;
      logic        ep;
      logic        st;
      logic        x_pred;
      logic        x_bt;
      logic        x_rt;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [15:0] pc,
                               input logic ev, input logic [15:0] epc, input logic et,
                               input logic ep, input logic st, input logic x_pred,
                               input logic x_bt, input logic x_rt);
      vec_t v;
      v.name = name; v.opc = opc; v.pc = pc; v.ev = ev; v.epc = epc; v.et = et;
      v.ep = ep; v.st = st; v.x_pred = x_pred; v.x_bt = x_bt; v.x_rt = x_rt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [6:0] opc, input logic [15:0] pc, input logic ev,
                        input logic [15:0] epc, input logic et, input logic ep, input logic st);
      if_opcode       = opc;
      if_pc           = PC_W'(pc);
      ex_branch_valid = ev;
      ex_pc           = PC_W'(epc);
      ex_taken        = et;
      ex_pred         = ep;
      stall           = st;
   endtask

   task automatic chk_out(input string name, input logic p, input logic bt, input logic rt);
      chk({name, ".pred"}, {31'd0, prediction}, {31'd0, p});
      chk({name, ".bt"}, {31'd0, branchtaken}, {31'd0, bt});
      chk({name, ".rt"}, {31'd0, redirect_taken}, {31'd0, rt});
      $display("%-14s pred=%0b bt=%0b rt=%0b", name, prediction, branchtaken, redirect_taken);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           name        opc     pc       ev  epc      et ep st  pred bt rt
      vecs[0]  = mk("rst_beq",  OP_BEQ, 16'h40, 0, 16'h00, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk("jump",     OP_JMP, 16'h40, 0, 16'h00, 0, 0, 0, 1, 0, 0);
      vecs[2]  = mk("alu",      OP_ALU, 16'h40, 0, 16'h00, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk("trn_t1",   OP_BEQ, 16'h40, 1, 16'h40, 1, 1, 0, 0, 0, 0);
      vecs[4]  = mk("trn_t2",   OP_BEQ, 16'h40, 1, 16'h40, 1, 1, 0, 1, 0, 0);
      vecs[5]  = mk("trn_t3",   OP_BEQ, 16'h40, 1, 16'h40, 1, 1, 0, 1, 0, 0);
      vecs[6]  = mk("sat_hi",   OP_BEQ, 16'h40, 0, 16'h00, 0, 0, 0, 1, 0, 0);
      vecs[7]  = mk("dec1",     OP_BEQ, 16'h40, 1, 16'h40, 0, 0, 0, 1, 0, 0);
      vecs[8]  = mk("dec2",     OP_BEQ, 16'h40, 1, 16'h40, 0, 0, 0, 1, 0, 0);
      vecs[9]  = mk("after_dec",OP_BEQ, 16'h40, 0, 16'h00, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk("same_cyc", OP_BEQ, 16'h44, 1, 16'h44, 1, 1, 0, 0, 0, 0);
      vecs[11] = mk("same_nxt", OP_BEQ, 16'h44, 0, 16'h00, 0, 0, 0, 1, 0, 0);
      vecs[12] = mk("mis_t",    OP_ALU, 16'h00, 1, 16'h80, 1, 0, 0, 0, 1, 1);
      vecs[13] = mk("mis_t_nxt",OP_BEQ, 16'h40, 0, 16'h00, 0, 0, 0, 1, 0, 0);
      vecs[14] = mk("mis_nt",   OP_ALU, 16'h00, 1, 16'h48, 0, 1, 0, 0, 1, 0);
      vecs[15] = mk("snt",      OP_BEQ, 16'h48, 0, 16'h00, 0, 0, 0, 0, 0, 0);
      vecs[16] = mk("sat_lo",   OP_BEQ, 16'h48, 1, 16'h48, 0, 0, 0, 0, 0, 0);
      vecs[17] = mk("up_lo",    OP_BEQ, 16'h48, 1, 16'h48, 1, 1, 0, 0, 0, 0);
      vecs[18] = mk("lo_chk",   OP_BEQ, 16'h48, 0, 16'h00, 0, 0, 0, 0, 0, 0);

      arst = 1'b1;
      drive(7'd0, 16'h0, 0, 16'h0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_out("reset", 0, 0, 0);
      arst = 1'b0;
      next_cycle();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].opc, vecs[i].pc, vecs[i].ev, vecs[i].epc, vecs[i].et, vecs[i].ep, vecs[i].st);
         @(negedge clk);
         chk_out(vecs[i].name, vecs[i].x_pred, vecs[i].x_bt, vecs[i].x_rt);
         next_cycle();
      end

      // Mispredict held across three stalled cycles; EX inputs in HOLD must be ignored.
      drive(OP_ALU, 16'h0, 1, 16'h4C, 1, 0, 1);
      @(negedge clk); chk_out("hold_a", 0, 1, 1); next_cycle();
      drive(OP_ALU, 16'h0, 1, 16'h50, 1, 1, 1);
      @(negedge clk); chk_out("hold_b", 0, 1, 1); next_cycle();
      drive(OP_ALU, 16'h0, 1, 16'h54, 0, 1, 1);
      @(negedge clk); chk_out("hold_c", 0, 1, 1); next_cycle();
      drive(OP_ALU, 16'h0, 0, 16'h0, 0, 0, 0);
      @(negedge clk); chk_out("hold_d", 0, 1, 1); next_cycle();
      drive(OP_BEQ, 16'h50, 0, 16'h0, 0, 0, 0);
      @(negedge clk); chk_out("hold_e", 0, 0, 0); next_cycle();
      drive(OP_BEQ, 16'h4C, 0, 16'h0, 0, 0, 0);
      @(negedge clk); chk_out("hold_trn", 1, 0, 0); next_cycle();

      // Reset asserted in the second HOLD cycle.
      drive(OP_BEQ, 16'h40, 1, 16'h60, 0, 1, 1);
      @(negedge clk); chk_out("rh_a", 1, 1, 0); next_cycle();
      drive(OP_BEQ, 16'h40, 0, 16'h0, 0, 0, 1);
      @(negedge clk); chk_out("rh_b", 1, 1, 0);
      #1 arst = 1'b1;
      #1 chk_out("rh_async", 0, 0, 0);
      @(negedge clk);
      arst = 1'b0;
      stall = 1'b0;
      next_cycle();
      @(negedge clk); chk_out("rh_after", 0, 0, 0);

`ifdef BRANCH_PRED_PERF_EN
      chk("perf_rst_br", {28'd0, branch_cnt}, 32'd0);
      chk("perf_rst_mis", {28'd0, mispred_cnt}, 32'd0);
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         drive(OP_ALU, 16'h0, 1, 16'h100 + 16'(4 * k), 1, (k < 2) ? 1'b0 : 1'b1, 0);
         next_cycle();
      end
      drive(OP_ALU, 16'h0, 0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("perf_br5", {28'd0, branch_cnt}, 32'd5);
      chk("perf_mis2", {28'd0, mispred_cnt}, 32'd2);
      $display("perf          br=%0d mis=%0d", branch_cnt, mispred_cnt);
      next_cycle();
      for (int k = 0; k < 10; k++) begin
         drive(OP_ALU, 16'h0, 1, 16'h200, 0, 0, 0);
         next_cycle();
      end
      drive(OP_ALU, 16'h0, 0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("perf_br15", {28'd0, branch_cnt}, 32'd15);
      next_cycle();
      drive(OP_ALU, 16'h0, 1, 16'h200, 0, 0, 0);
      next_cycle();
      drive(OP_ALU, 16'h0, 0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("perf_wrap", {28'd0, branch_cnt}, 32'd0);
      chk("perf_mis_keep", {28'd0, mispred_cnt}, 32'd2);
      $display("perf wrap     br=%0d mis=%0d", branch_cnt, mispred_cnt);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and mispredict flush sequencer for the 5-stage RISC-V pipeline. Looks up a table of 2-bit saturating counters with the IF-stage PC and drives the control unit's `prediction` input. Trains the table with branch outcomes resolved in EX. On a mispredict it generates the `branchtaken`/redirect pulse that flushes IF/ID and ID/EX, holding the pulse across pipeline stalls until the front end accepts it.

## Interface
Parameters:
- `PC_W`, 64, PC width.
- `IDX_W`, 4, table index width; the table has 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- `CNT_W`, 32, width of the performance counters (only used with `BRANCH_PRED_PERF_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `arst`  in  1  asynchronous reset, active-high.
- `if_pc`  in  PC_W  PC of the instruction in IF.
- `if_opcode`  in  7  opcode[6:0] of the instruction in IF.
- `prediction`  out  1  predict-taken for the IF instruction; combinational.
- `ex_branch_valid`  in  1  a conditional branch is resolved in EX this cycle.
- `ex_pc`  in  PC_W  PC of the EX branch.
- `ex_taken`  in  1  actual branch outcome.
- `ex_pred`  in  1  prediction carried down the pipe with that branch.
- `stall`  in  1  front end cannot accept a redirect this cycle.
- `branchtaken`  out  1  flush/redirect request to IF/ID, ID/EX and the control unit.
- `redirect_taken`  out  1  with `branchtaken`: 1 selects the branch target, 0 selects ex_pc+4.
- `branch_cnt`  out  CNT_W  resolved-branch count (only with `BRANCH_PRED_PERF_EN`).
- `mispred_cnt`  out  CNT_W  mispredict count (only with `BRANCH_PRED_PERF_EN`).

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit[1] = 1.
- Prediction:
  - if_opcode = 1100011 (BRANCH_EQ): `prediction` = counter[if_pc[IDX_W+1:2]][1].
  - if_opcode = 1101111 (JUMP): `prediction` = 1.
  - Any other opcode: 0.
- Training: when `ex_branch_valid` is high, the entry at ex_pc[IDX_W+1:2] saturating-increments if `ex_taken`, otherwise saturating-decrements. 11+taken stays 11; 00+not-taken stays 00.
- Mispredict: `mis = ex_branch_valid & (ex_taken != ex_pred)`.
- Redirect FSM:
  - IDLE: if `mis` and not `stall`, assert `branchtaken` combinationally this cycle and stay in IDLE. If `mis` and `stall`, latch `ex_taken` into `redirect_taken` and go to HOLD.
  - HOLD: `branchtaken` = 1 with the latched `redirect_taken`. Return to IDLE on the first cycle with `stall` = 0; that is the last cycle `branchtaken` is asserted.
  - In HOLD, `ex_branch_valid` is ignored for both training and mispredict (EX is frozen).
- Reset values:
  - All counters 01.
  - FSM IDLE.
  - `branchtaken` = 0, `redirect_taken` = 0.
  - Perf counters 0.

## Timing
- Prediction is combinational from `if_pc`/`if_opcode`, with zero cycles of latency.
- A table update becomes visible on the cycle after the training edge.
- Same index read in IF and written from EX in the same cycle: IF sees the old value; there is no bypass.
- In IDLE, `branchtaken` is combinational from the EX inputs. In HOLD it is registered.
- Reset asserted mid-HOLD: return to IDLE immediately, and `branchtaken` drops asynchronously.
- `mis` arriving while already in HOLD cannot occur, because EX is stalled; it is ignored.

## Configuration
- `BRANCH_PRED_PERF_EN` defined:
  - `branch_cnt` increments on every accepted `ex_branch_valid`.
  - `mispred_cnt` increments on every accepted `mis`.
  - Both wrap modulo 2^CNT_W.
- Not defined: both ports and counters are absent, with no other behavioural difference.

## Structure
- Shared package `branch_pred_pkg`:
  - Opcode constants BRANCH_EQ = 7'b1100011 and JUMP = 7'b1101111.
  - 2-bit counter typedef and encodings STRONG_NT/WEAK_NT/WEAK_T/STRONG_T.
  - Redirect FSM state enum IDLE/HOLD.
- One sub-module `bht_table`: counter array with async reset to WEAK_NT, one combinational read port and one saturating-update write port.
- Redirect FSM and perf counters live in the top level.

## Test plan
- Reset, then BRANCH_EQ at if_pc=0x40 -> `prediction`=0 (entry 0 = 01); JUMP opcode -> `prediction`=1; opcode 0110011 -> 0.
- Two taken trainings at ex_pc=0x40 -> entry goes 01→10→11; `prediction` for 0x40 is 1 from the cycle after the first update. A third taken keeps it at 11.
- Same-cycle IF read and EX taken-update of entry 0x44 (counter 01) -> `prediction`=0 that cycle and 1 the next.
- `ex_branch_valid`=1, `ex_taken`=1, `ex_pred`=0, `stall`=0 -> `branchtaken`=1 and `redirect_taken`=1 in the same cycle only.
- Same mispredict with `stall` high for 3 cycles -> `branchtaken` high for 4 cycles with `redirect_taken`=1, then 0. `arst` asserted in the 2nd HOLD cycle -> `branchtaken`=0 immediately.
- With `BRANCH_PRED_PERF_EN`: 5 branches including 2 mispredicts -> `branch_cnt`=5, `mispred_cnt`=2. Preload `branch_cnt` to 2^CNT_W-1 plus one branch -> wraps to 0.
